// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port synchronous data RAM between the core (port 0) and a secondary requester (port 1).
// Optional feature: define DMEM_ARB_STARVE_EN to add the port-1 starvation counter and forced grant.
module dmem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] rsel_q, rsel_d;
    logic       force_m1;

`ifdef DMEM_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign force_m1 = m1_req && (starve_cnt_q >= 4'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || m1_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_m1 = 1'b0;
`endif

    // Grants are suppressed while reset is held so no RAM strobe escapes during reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset) begin
            if (force_m1) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // One-hot record of which port owns the read data arriving next cycle.
    always_comb begin
        rsel_d = {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsel_q <= 2'b00;
        end else begin
            rsel_q <= rsel_d;
        end
    end

    assign m0_rvalid = rsel_q[0];
    assign m1_rvalid = rsel_q[1];
    assign m0_rdata  = rsel_q[0] ? mem_rdata : '0;
    assign m1_rdata  = rsel_q[1] ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected read returns, a negedge monitor pops and compares.
module tb_dmem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic              ram_init_done = 1'b0;
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    exp_t              sb_q [$];
    int                errors = 0;
    int                checks = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model; preloaded on its first clock edge.
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'hC0DE_0000 | i;
            ram[2] <= 32'h0000_0011;
            ram[3] <= 32'h0000_0022;
            ram_init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid || m1_rvalid) begin
            check_output("rvalid_exclusive", 32'(m0_rvalid & m1_rvalid), 32'd0);
            if (sb_q.size() == 0) begin
                check_output("unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_output("rvalid_port", {30'd0, m1_rvalid, m0_rvalid}, e.port ? 32'd2 : 32'd1);
                if (e.port) begin
                    check_output("m1_rdata", m1_rdata, e.data);
                    check_output("m0_rdata_idle", m0_rdata, 32'd0);
                end else begin
                    check_output("m0_rdata", m0_rdata, e.data);
                    check_output("m1_rdata_idle", m1_rdata, 32'd0);
                end
            end
        end else begin
            check_output("m0_rdata_zero", m0_rdata, 32'd0);
            check_output("m1_rdata_zero", m1_rdata, 32'd0);
        end
    end

    task automatic apply_stimulus(input logic r0, input logic we0, input logic [ADDR_W-1:0] a0,
                                  input logic [DATA_W-1:0] d0,
                                  input logic r1, input logic we1, input logic [ADDR_W-1:0] a1,
                                  input logic [DATA_W-1:0] d1,
                                  input logic eg0, input logic eg1, input string tag);
        logic              ewe;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        @(posedge clk);
        #1;
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        @(negedge clk);
        ewe = 1'b0; ea = '0; ed = '0;
        if (eg0) begin
            ewe = we0; ea = a0; ed = d0;
        end else if (eg1) begin
            ewe = we1; ea = a1; ed = d1;
        end
        check_output({tag, " m0_gnt"}, 32'(m0_gnt), 32'(eg0));
        check_output({tag, " m1_gnt"}, 32'(m1_gnt), 32'(eg1));
        check_output({tag, " mem_en"}, 32'(mem_en), 32'(eg0 | eg1));
        check_output({tag, " mem_we"}, 32'(mem_we), 32'(ewe));
        check_output({tag, " mem_addr"}, 32'(mem_addr), 32'(ea));
        check_output({tag, " mem_wdata"}, mem_wdata, ed);
        if (eg0 || eg1) begin
            if (ewe) ref_mem[ea] = ed;
            else     sb_q.push_back('{port: eg1, data: ref_mem[ea]});
        end
    endtask

    task automatic check_reset_hold(input string tag);
        @(posedge clk);
        #1;
        m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b0;
        @(negedge clk);
        check_output({tag, " m0_gnt"}, 32'(m0_gnt), 32'd0);
        check_output({tag, " m1_gnt"}, 32'(m1_gnt), 32'd0);
        check_output({tag, " mem_en"}, 32'(mem_en), 32'd0);
        check_output({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check_output({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a0, a1;
        logic              g1;
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 32'hC0DE_0000 | i;
        ref_mem[2] = 32'h0000_0011;
        ref_mem[3] = 32'h0000_0022;

        #2 reset = 1'b0;
        check_reset_hold("reset_init");
        check_reset_hold("reset_init");
        m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        apply_stimulus(1, 1, 6'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, "p0_write");
        apply_stimulus(1, 0, 6'd5, 0, 0, 0, 0, 0, 1, 0, "p0_read");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");

        apply_stimulus(1, 0, 6'd2, 0, 0, 0, 0, 0, 1, 0, "p0_read2");
        apply_stimulus(0, 0, 0, 0, 1, 0, 6'd3, 0, 0, 1, "p1_read3");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");

        // Contention: port 1 forced in on every fifth cycle only when the guard is built in.
        a0 = 6'd10; a1 = 6'd20;
        for (int i = 0; i < 10; i++) begin
            g1 = STARVE_ON && (i % 5 == 4);
            apply_stimulus(1, 0, a0, 0, 1, 0, a1, 0, !g1, g1, "contend");
            if (g1) a1++;
            else    a0++;
        end
        apply_stimulus(0, 0, 0, 0, 1, 0, a1, 0, 0, 1, "m0_drop");
        apply_stimulus(0, 0, 0, 0, 1, 1, 6'd30, 32'h1234_5678, 0, 1, "p1_write");
        apply_stimulus(1, 0, 6'd30, 0, 0, 0, 0, 0, 1, 0, "p0_read30");

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, a0, 0, 1, 0, 6'd40, 0, 1, 0, "pre_reset");
            a0++;
        end
        apply_stimulus(0, 0, 0, 0, 1, 0, 6'd40, 0, 0, 1, "p1_read40");
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete(sb_q.size() - 1);
        @(negedge clk);
        check_output("reset_mid m1_rvalid", 32'(m1_rvalid), 32'd0);
        check_reset_hold("reset_mid");
        check_reset_hold("reset_mid");
        m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        reset = 1'b1;

        a0 = 6'd50; a1 = 6'd60;
        for (int i = 0; i < 5; i++) begin
            g1 = STARVE_ON && (i == 4);
            apply_stimulus(1, 0, a0, 0, 1, 0, a1, 0, !g1, g1, "post_reset");
            if (g1) a1++;
            else    a0++;
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");
        @(posedge clk);
        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
